minutos: RTL
============

// Module: minutos
// PURPOSE
//  Minute counter of the clock chain, and the source of the hour-increment pulse consumed by the hour counter.
//  - Counts minute-tick pulses from the seconds stage.
//  - Wraps at MOD_MIN.
//  - Also accepts manual minute/hour adjust requests.
//  - Emits hour increments as single-cycle pulses on inc_hora_o.
//  A small pending counter queues hour events, so simultaneous sources are never lost.
// PARAMETERS
//  MOD_MIN  60  minute modulus; legal range 2..64 (count 0..MOD_MIN-1 fits 6 bits)
//  PEND_W   2   width of pending hour-event counter; saturates at 2**PEND_W-1
// PORTS
//  clk_i        in   1  clock
//  rst_i        in   1  reset; asynchronous and active-high; clears all state
//  inc_min_i    in   1  minute tick, 1-cycle pulse from seconds stage; may be high every cycle
//  adj_min_i    in   1  manual +1 minute; wraps, never generates an hour event
//  adj_hora_i   in   1  manual +1 hour; generates one hour event per cycle high
//  clr_i        in   1  synchronous clear; highest priority below rst_i
//  minutos_o    out  6  current minute count, registered
//  inc_hora_o   out  1  hour-increment pulse to hour counter, registered, 1 pulse = +1 hour
//  ovf_o        out  1  sticky: an hour event was dropped because pending counter was saturated
// BEHAVIOUR
//  Reset (rst_i=1, async): minutos_o=0, inc_hora_o=0, ovf_o=0, pend=0; outputs drop immediately.
//  Priority each edge: clr_i > inc_min_i > adj_min_i.
//  Minute update:
//   - clr_i=1: minutos_o<=0, pend<=0, inc_hora_o<=0, ovf_o<=0; all other inputs ignored.
//   - inc_min_i=1: minutos_o<=(m==MOD_MIN-1)?0:m+1; wrap sets wrap_ev=1.
//   - inc_min_i=0, adj_min_i=1: same wrap arithmetic, wrap_ev=0.
//   - adj_min_i is ignored (not deferred) when inc_min_i=1 in the same cycle.
//  Hour events: new = wrap_ev + adj_hora_i (0..2 per cycle); tot = pend + new.
//   - inc_hora_o <= (tot != 0); latency 1 cycle from the sampling edge to the pulse.
//   - rem = tot - (tot!=0 ? 1 : 0).
//   - pend <= min(rem, 2**PEND_W-1); if rem > 2**PEND_W-1, ovf_o <= 1 (sticky).
//   - At most one pulse per cycle; back-to-back pulses are legal (one per cycle while pend>0).
//   - Pulse order is irrelevant: every event yields exactly one +1 to the hours stage.
//  Width rules: arithmetic on minutos in 6 bits with explicit compare to MOD_MIN-1; tot held in PEND_W+1 bits.
//  Boundary conditions:
//   - Minute wrap and adj_hora_i in the same cycle give two consecutive pulses, no loss.
//   - Saturation drops only the excess event and flags ovf_o; counting continues.
//   - Reset or clr_i mid-queue discards pending events; no pulse follows.
//  No combinational path from any input to any output.
// TESTING
//  T1 m=37, rst_i pulsed asynchronously mid-cycle -> minutos_o=0, inc_hora_o=0, ovf_o=0 before next edge.
//  T2 From 0, 60 inc_min_i pulses, spaced 3 cycles apart -> minutos_o goes 59->0 on 60th; inc_hora_o=1 one cycle exactly, 1 cycle after that edge.
//  T3 m=59, inc_min_i=1 and adj_hora_i=1 same cycle -> minutos_o=0; inc_hora_o high 2 consecutive cycles, then 0; ovf_o=0.
//  T4 m=59, adj_min_i=1 alone -> minutos_o=0, inc_hora_o stays 0; m=10 with inc_min_i=adj_min_i=1 -> minutos_o=11.
//  T5 MOD_MIN=2, PEND_W=1, inc_min_i=adj_hora_i=1 held 8 cycles -> inc_hora_o high every cycle from cycle 1; ovf_o=1 within 6 cycles.
//  T6 After T5, clr_i=1 one cycle -> next cycle minutos_o=0, inc_hora_o=0, ovf_o=0; no further pulses.

Source files
------------

// File: rtl/minutos.sv
// Minute counter: counts minute ticks modulo MOD_MIN, takes manual adjusts, and
// turns minute wraps plus manual hour requests into a queue of single-cycle hour pulses.
module minutos #(
    parameter int MOD_MIN = 60,
    parameter int PEND_W  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_min_i,
    input  logic       adj_min_i,
    input  logic       adj_hora_i,
    input  logic       clr_i,
    output logic [5:0] minutos_o,
    output logic       inc_hora_o,
    output logic       ovf_o
);

    localparam logic [5:0]      MIN_LAST = 6'(MOD_MIN - 1);
    localparam logic [PEND_W:0] PEND_MAX = (PEND_W+1)'((1 << PEND_W) - 1);

    logic [5:0]        min_q, min_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              inc_hora_q, inc_hora_d;
    logic              ovf_q, ovf_d;

    logic              wrap_ev;
    logic              step;
    logic [PEND_W:0]   new_ev;
    logic [PEND_W:0]   tot;
    logic [PEND_W:0]   rem;

    always_comb begin
        min_d      = min_q;
        pend_d     = pend_q;
        inc_hora_d = 1'b0;
        ovf_d      = ovf_q;
        wrap_ev    = 1'b0;
        step       = 1'b0;
        new_ev     = '0;
        tot        = '0;
        rem        = '0;

        if (clr_i) begin
            min_d  = '0;
            pend_d = '0;
            ovf_d  = 1'b0;
        end else begin
            // adj_min_i is dropped, not deferred, when a real tick arrives together
            step = inc_min_i | adj_min_i;
            if (step) begin
                if (min_q == MIN_LAST) begin
                    min_d   = '0;
                    wrap_ev = inc_min_i;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end

            new_ev     = (PEND_W+1)'(wrap_ev) + (PEND_W+1)'(adj_hora_i);
            tot        = {1'b0, pend_q} + new_ev;
            inc_hora_d = (tot != '0);
            rem        = tot - (PEND_W+1)'(inc_hora_d);

            if (rem > PEND_MAX) begin
                pend_d = PEND_MAX[PEND_W-1:0];
                ovf_d  = 1'b1;
            end else begin
                pend_d = rem[PEND_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            min_q      <= '0;
            pend_q     <= '0;
            inc_hora_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            min_q      <= min_d;
            pend_q     <= pend_d;
            inc_hora_q <= inc_hora_d;
            ovf_q      <= ovf_d;
        end
    end

    assign minutos_o  = min_q;
    assign inc_hora_o = inc_hora_q;
    assign ovf_o      = ovf_q;

endmodule
